// File: rtl/xadc.sv
`default_nettype none
// ============================================================================
// Module      : xadc
// Description : Behavioural 12-bit SAR ADC. It resolves an internal sample
//               MSB-first, one bit per clock, and ends with an EOC strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module xadc #(
    parameter int          ACQ_CYCLES  = 4,
    parameter logic [11:0] INIT_SAMPLE = 12'h800,
    parameter logic [11:0] SAMPLE_STEP = 12'h011
) (
    input  logic        AdcClk,
    input  logic        AdcRst,
    input  logic        AdcSoc,
    output logic        AdcEoc,
    output logic [11:0] AdcData,
    output logic        AdcBusy
);

    localparam logic [7:0] c_ACQ_LOAD = 8'(ACQ_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        CONV = 2'd2
    } state_t;

    state_t      r_state;
    logic [11:0] r_sampleSrc;
    logic [11:0] r_holdVal;
    logic [11:0] r_result;
    logic [7:0]  r_acqCnt;
    logic [3:0]  r_bitIdx;

    logic [11:0] w_trial;
    logic [11:0] w_nextResult;

    // One comparator step: keep the trial bit if the held sample covers it.
    assign w_trial      = r_result | (12'd1 << r_bitIdx);
    assign w_nextResult = (r_holdVal >= w_trial) ? w_trial : r_result;

    always_ff @(posedge AdcClk) begin
        if (AdcRst) begin
            r_state     <= IDLE;
            r_sampleSrc <= INIT_SAMPLE;
            r_holdVal   <= 12'h000;
            r_result    <= 12'h000;
            r_acqCnt    <= 8'd0;
            r_bitIdx    <= 4'd0;
            AdcData     <= 12'h000;
            AdcEoc      <= 1'b0;
            AdcBusy     <= 1'b0;
        end else begin
            AdcEoc <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (AdcSoc) begin
                        r_holdVal   <= r_sampleSrc;
                        r_sampleSrc <= r_sampleSrc + SAMPLE_STEP;
                        r_acqCnt    <= c_ACQ_LOAD;
                        AdcBusy     <= 1'b1;
                        r_state     <= ACQ;
                    end
                end
                ACQ: begin
                    if (r_acqCnt == 8'd0) begin
                        r_bitIdx <= 4'd11;
                        r_result <= 12'h000;
                        r_state  <= CONV;
                    end else begin
                        r_acqCnt <= r_acqCnt - 8'd1;
                    end
                end
                CONV: begin
                    r_result <= w_nextResult;
                    if (r_bitIdx == 4'd0) begin
                        AdcData <= w_nextResult;
                        AdcEoc  <= 1'b1;
                        AdcBusy <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_bitIdx <= r_bitIdx - 4'd1;
                    end
                end
                default: begin
                    AdcBusy <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xadc.sv
`default_nettype none
// ============================================================================
// Module      : tb_xadc
// Description : Directed scoreboard bench for xadc (three parameterisations).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xadc;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  soc;
    logic [2:0]  eoc;
    logic [2:0]  busy;
    logic [11:0] data [3];

    int checks   = 0;
    int failures = 0;
    int overlap  = 0;
    logic [11:0] expQ[$];

    always #5 clk = ~clk;

    xadc u_dflt (
        .AdcClk(clk), .AdcRst(rst), .AdcSoc(soc[0]),
        .AdcEoc(eoc[0]), .AdcData(data[0]), .AdcBusy(busy[0])
    );

    xadc #(.ACQ_CYCLES(4), .INIT_SAMPLE(12'hFFF), .SAMPLE_STEP(12'h00A)) u_wrap (
        .AdcClk(clk), .AdcRst(rst), .AdcSoc(soc[1]),
        .AdcEoc(eoc[1]), .AdcData(data[1]), .AdcBusy(busy[1])
    );

    xadc #(.ACQ_CYCLES(1), .INIT_SAMPLE(12'h000), .SAMPLE_STEP(12'h011)) u_min (
        .AdcClk(clk), .AdcRst(rst), .AdcSoc(soc[2]),
        .AdcEoc(eoc[2]), .AdcData(data[2]), .AdcBusy(busy[2])
    );

    always @(negedge clk) begin
        if ((eoc & busy) != 3'b000) overlap++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkPop(input string tag, input int idx);
        logic [11:0] e;
        if (expQ.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, data[idx]);
        end else begin
            e = expQ.pop_front();
            check(tag, 32'(data[idx]), 32'(e));
        end
    endtask

    // Steps until eoc[idx] is seen; lat counts edges since the caller's last step.
    task automatic waitEoc(input string tag, input int idx, output int lat);
        lat = 0;
        while (!eoc[idx] && lat < 100) begin
            step();
            lat++;
        end
        if (!eoc[idx]) begin
            checks++;
            failures++;
            $error("FAIL %s observed=timeout expected=eoc within 100 cycles", tag);
        end
    endtask

    task automatic convert(input string tag, input int idx, input logic [11:0] exp,
                           input int expLat);
        int lat;
        soc[idx] = 1'b1;
        step();
        soc[idx] = 1'b0;
        expQ.push_back(exp);
        waitEoc(tag, idx, lat);
        if (eoc[idx]) begin
            check({tag, "_lat"}, 32'(lat), 32'(expLat));
            check({tag, "_busy"}, 32'(busy[idx]), 32'd0);
            checkPop({tag, "_data"}, idx);
        end
    endtask

    initial begin
        int lat;
        int eocCnt;
        int eocPos [2];

        rst = 1'b1;
        soc = 3'b000;
        step();
        step();
        check("rst_data", 32'(data[0]), 32'h000);
        check("rst_eoc", 32'(eoc[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        rst = 1'b0;
        step();

        // Single pulse: busy over edges N..N+15, eoc after N+16.
        soc[0] = 1'b1;
        step();
        soc[0] = 1'b0;
        expQ.push_back(12'h800);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("pulse_busy_%0d", k), 32'({busy[0], eoc[0]}), 32'b10);
            step();
        end
        check("pulse_eoc", 32'({busy[0], eoc[0]}), 32'b01);
        checkPop("pulse_data", 0);
        step();
        check("pulse_eoc_drop", 32'(eoc[0]), 32'd0);
        check("pulse_hold", 32'(data[0]), 32'h800);

        convert("second", 0, 12'h811, 16);

        // Wrap-around of the sample source.
        convert("wrap0", 1, 12'hFFF, 16);
        convert("wrap1", 1, 12'h009, 16);
        convert("wrap2", 1, 12'h013, 16);

        // Held request: accepts at N, N+17, N+34.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        expQ.push_back(12'h800);
        expQ.push_back(12'h811);
        expQ.push_back(12'h822);
        eocCnt = 0;
        soc[0] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (eoc[0]) begin
                if (eocCnt < 2) eocPos[eocCnt] = i;
                eocCnt++;
                checkPop($sformatf("held_data_%0d", eocCnt), 0);
            end
        end
        soc[0] = 1'b0;
        check("held_count", 32'(eocCnt), 32'd2);
        check("held_first", 32'(eocPos[0]), 32'd16);
        check("held_spacing", 32'(eocPos[1] - eocPos[0]), 32'd17);
        waitEoc("held_third", 0, lat);
        if (eoc[0]) begin
            check("held_third_lat", 32'(lat), 32'd11);
            checkPop("held_third_data", 0);
        end

        // Requests while busy must not queue another conversion.
        step();
        soc[0] = 1'b1;
        step();
        soc[0] = 1'b0;
        expQ.push_back(12'h833);
        repeat (3) step();
        soc[0] = 1'b1;
        step();
        soc[0] = 1'b0;
        repeat (5) step();
        soc[0] = 1'b1;
        step();
        soc[0] = 1'b0;
        waitEoc("busyreq", 0, lat);
        if (eoc[0]) checkPop("busyreq_data", 0);
        eocCnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (eoc[0] || busy[0]) eocCnt++;
        end
        check("busyreq_no_extra", 32'(eocCnt), 32'd0);
        convert("after_busyreq", 0, 12'h844, 16);

        // Reset during CONV aborts without a strobe.
        soc[0] = 1'b1;
        step();
        soc[0] = 1'b0;
        repeat (8) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_state", 32'({busy[0], eoc[0], data[0]}), 32'h000);
        step();
        convert("post_abort", 0, 12'h800, 16);

        // Minimum acquisition, all trials rejected.
        convert("min", 2, 12'h000, 13);

        check("eoc_busy_overlap", 32'(overlap), 32'd0);
        check("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
